shift_mac_sequencer: RTL and testbench



---
 rtl/shift_mac_pkg.sv | 8 +
 rtl/shift_mac_acc.sv | 29 ++
 rtl/shift_mac_sequencer.sv | 77 +++++++
 tb/tb_shift_mac_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_mac_pkg.sv
// shift_mac_pkg: shared state encoding and shift-unit interface widths for the shift MAC sequencer.
package shift_mac_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int SH_LAT = 1;
    localparam int SH_PROD_W = 32;
    localparam int W_W = 4;
    localparam int A_W = 8;
endpackage

// File: rtl/shift_mac_acc.sv
// shift_mac_acc: dot-product accumulator; sign-extends or truncates each shift-unit product to ACC_W.
module shift_mac_acc
    import shift_mac_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 en,
    input  logic [SH_PROD_W-1:0] product,
    output logic [ACC_W-1:0]     acc
);
    logic [ACC_W-1:0] ext;

    generate
        if (ACC_W > SH_PROD_W) begin : g_sext
            assign ext = {{(ACC_W-SH_PROD_W){product[SH_PROD_W-1]}}, product};
        end else begin : g_trunc
            assign ext = product[ACC_W-1:0];
        end
    endgenerate

    // Clear beats enable so an abort drops the in-flight product.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) acc <= '0;
        else if (clear) acc <= '0;
        else if (en) acc <= acc + ext;
endmodule

// File: rtl/shift_mac_sequencer.sv
// shift_mac_sequencer: feeds weight/activation pairs into a 1-cycle shift multiplier
// and accumulates the returned products into a dot product on a valid/ready result port.
module shift_mac_sequencer
    import shift_mac_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic [LEN_W-1:0]     i_len,
    input  logic                 i_abort,
    output logic                 o_busy,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [W_W-1:0]       i_weight,
    input  logic [A_W-1:0]       i_activation,
    output logic [W_W-1:0]       o_sh_weight,
    output logic [A_W-1:0]       o_sh_activation,
    input  logic [SH_PROD_W-1:0] i_sh_product,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [ACC_W-1:0]     o_out_sum
);
    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic             p_valid;
    logic             accept;
    logic             acc_clear;

    assign o_in_ready      = state == RUN;
    assign o_busy          = state != IDLE;
    assign o_out_valid     = state == DONE;
    assign accept          = i_in_valid & o_in_ready;
    assign o_sh_weight     = accept ? i_weight : '0;
    assign o_sh_activation = accept ? i_activation : '0;
    assign acc_clear       = i_abort | (state == IDLE & i_start);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state   <= IDLE;
            len_q   <= '0;
            count   <= '0;
            p_valid <= 1'b0;
        end else if (i_abort) begin
            state   <= IDLE;
            count   <= '0;
            p_valid <= 1'b0;
        end else begin
            p_valid <= accept;
            case (state)
                IDLE: if (i_start) begin
                    len_q <= i_len;
                    count <= '0;
                    state <= (i_len != '0) ? RUN : DONE;
                end
                RUN: if (accept) begin
                    count <= count + 1'b1;
                    if (count == len_q - 1'b1) state <= DRAIN;
                end
                DRAIN: state <= DONE;
                DONE: if (i_out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end

    shift_mac_acc #(.ACC_W(ACC_W)) u_acc (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (acc_clear),
        .en     (p_valid),
        .product(i_sh_product),
        .acc    (o_out_sum)
    );
endmodule

// File: tb/tb_shift_mac_sequencer.sv
// tb_shift_mac_sequencer: scenario tasks around a behavioural shift unit; expected sums queued per job.
module tb_shift_mac_sequencer;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        i_start = 0;
    logic [7:0]  i_len = 0;
    logic        i_abort = 0;
    logic        o_busy;
    logic        i_in_valid = 0;
    logic        o_in_ready;
    logic [3:0]  i_weight = 0;
    logic [7:0]  i_activation = 0;
    logic [3:0]  o_sh_weight;
    logic [7:0]  o_sh_activation;
    logic [31:0] i_sh_product;
    logic        o_out_valid;
    logic        i_out_ready = 0;
    logic [31:0] o_out_sum;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_acc;
    logic [31:0] exp_q[$];

    shift_mac_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_start        (i_start),
        .i_len          (i_len),
        .i_abort        (i_abort),
        .o_busy         (o_busy),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .i_weight       (i_weight),
        .i_activation   (i_activation),
        .o_sh_weight    (o_sh_weight),
        .o_sh_activation(o_sh_activation),
        .i_sh_product   (i_sh_product),
        .o_out_valid    (o_out_valid),
        .i_out_ready    (i_out_ready),
        .o_out_sum      (o_out_sum)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sh(input logic [3:0] w, input logic [7:0] a);
        logic [31:0] m;
        m = (w[2:0] == 3'd0) ? 32'd0 : ({24'd0, a} << (w[2:0] - 3'd1));
        return w[3] ? -m : m;
    endfunction

    // Behavioural shift unit with one cycle of latency.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) i_sh_product <= '0;
        else i_sh_product <= sh(o_sh_weight, o_sh_activation);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n);
        exp_acc = 0;
        i_start = 1;
        i_len = n;
        tick;
        i_start = 0;
        i_len = 0;
    endtask

    task automatic send(input logic [3:0] w, input logic [7:0] a);
        i_in_valid = 1;
        i_weight = w;
        i_activation = a;
        #1;
        checks++;
        if (o_sh_weight !== w || o_sh_activation !== a) begin
            failures++;
            $display("FAIL sh_drive got w=%h a=%0d expected w=%h a=%0d", o_sh_weight, o_sh_activation, w, a);
        end
        exp_acc = exp_acc + sh(w, a);
        tick;
        i_in_valid = 0;
        i_weight = 0;
        i_activation = 0;
    endtask

    task automatic wait_result(input string name);
        int n = 0;
        logic [31:0] e;
        while (o_out_valid !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (o_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout o_out_valid=%b expected 1", name, o_out_valid);
        end else begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (o_out_sum !== e) begin
                failures++;
                $display("FAIL %s_sum got %0d expected %0d", name, $signed(o_out_sum), $signed(e));
            end
        end
        i_out_ready = 1;
        tick;
        i_out_ready = 0;
        checks++;
        if (o_out_valid !== 0 || o_busy !== 0) begin
            failures++;
            $display("FAIL %s_release valid=%b busy=%b expected 0 0", name, o_out_valid, o_busy);
        end
    endtask

    task automatic test_reset;
        reset_n = 0;
        repeat (2) tick;
        checks++;
        if ({o_busy, o_in_ready, o_out_valid} !== 3'b000 || o_out_sum !== 0 || o_sh_weight !== 0 || o_sh_activation !== 0) begin
            failures++;
            $display("FAIL reset busy=%b rdy=%b vld=%b sum=%0d shw=%h sha=%0d expected all 0",
                     o_busy, o_in_ready, o_out_valid, o_out_sum, o_sh_weight, o_sh_activation);
        end
        reset_n = 1;
        tick;
    endtask

    task automatic test_back_to_back;
        start_job(3);
        checks++;
        if (o_in_ready !== 1 || o_busy !== 1) begin
            failures++;
            $display("FAIL b2b_run rdy=%b busy=%b expected 1 1", o_in_ready, o_busy);
        end
        send(4'h3, 10);
        send(4'hA, 5);
        send(4'h1, 7);
        exp_q.push_back(exp_acc);
        checks++;
        if (o_out_valid !== 0 || o_in_ready !== 0) begin
            failures++;
            $display("FAIL b2b_drain vld=%b rdy=%b expected 0 0", o_out_valid, o_in_ready);
        end
        tick;
        checks++;
        if (o_out_valid !== 1) begin
            failures++;
            $display("FAIL b2b_latency vld=%b expected 1 two clocks after last accept", o_out_valid);
        end
        wait_result("b2b");
    endtask

    task automatic test_zero_len;
        start_job(0);
        checks++;
        if (o_in_ready !== 0 || o_out_valid !== 1 || o_out_sum !== 0) begin
            failures++;
            $display("FAIL zero_len rdy=%b vld=%b sum=%0d expected 0 1 0", o_in_ready, o_out_valid, o_out_sum);
        end
        exp_q.push_back(0);
        wait_result("zero_len");
    endtask

    task automatic test_bubbles;
        start_job(4);
        for (int i = 0; i < 4; i++) begin
            i_in_valid = 0;
            i_weight = 4'h7;
            i_activation = 8'd255;
            #1;
            checks++;
            if (o_sh_weight !== 0 || o_sh_activation !== 0 || o_in_ready !== 1) begin
                failures++;
                $display("FAIL bubble_gate shw=%h sha=%0d rdy=%b expected 0 0 1", o_sh_weight, o_sh_activation, o_in_ready);
            end
            tick;
            send(4'h7, 8'd255);
        end
        exp_q.push_back(exp_acc);
        checks++;
        if (o_in_ready !== 0) begin
            failures++;
            $display("FAIL bubble_count rdy=%b expected 0 after 4 pairs", o_in_ready);
        end
        wait_result("bubbles");
    endtask

    task automatic test_hold_done;
        start_job(1);
        send(4'h1, 9);
        exp_q.push_back(exp_acc);
        tick;
        for (int i = 0; i < 5; i++) begin
            i_start = 1;
            i_len = 3;
            tick;
            checks++;
            if (o_out_valid !== 1 || o_out_sum !== exp_q[0]) begin
                failures++;
                $display("FAIL hold_done vld=%b sum=%0d expected 1 %0d", o_out_valid, o_out_sum, exp_q[0]);
            end
        end
        checks++;
        if (o_out_sum !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL hold_sum got %0d", o_out_sum);
        end
        i_out_ready = 1;
        tick;
        i_out_ready = 0;
        i_start = 0;
        i_len = 0;
        checks++;
        if (o_busy !== 0 || o_out_valid !== 0) begin
            failures++;
            $display("FAIL hold_start_ignored busy=%b vld=%b expected 0 0", o_busy, o_out_valid);
        end
    endtask

    task automatic test_abort;
        start_job(5);
        send(4'h3, 1);
        send(4'h3, 1);
        i_abort = 1;
        tick;
        i_abort = 0;
        checks++;
        if (o_busy !== 0 || o_out_valid !== 0 || o_out_sum !== 0) begin
            failures++;
            $display("FAIL abort busy=%b vld=%b sum=%0d expected 0 0 0", o_busy, o_out_valid, o_out_sum);
        end
        i_abort = 1;
        i_start = 1;
        i_len = 2;
        tick;
        i_abort = 0;
        i_start = 0;
        i_len = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_busy !== 0 || o_out_valid !== 0) begin
                failures++;
                $display("FAIL abort_idle busy=%b vld=%b expected 0 0", o_busy, o_out_valid);
            end
            tick;
        end
        start_job(1);
        send(4'h2, 3);
        exp_q.push_back(exp_acc);
        wait_result("after_abort");
    endtask

    task automatic test_reset_drain;
        start_job(2);
        send(4'h8, 77);
        send(4'h0, 55);
        reset_n = 0;
        #1;
        checks++;
        if ({o_busy, o_in_ready, o_out_valid} !== 3'b000 || o_out_sum !== 0 || o_sh_weight !== 0 || o_sh_activation !== 0) begin
            failures++;
            $display("FAIL reset_drain busy=%b rdy=%b vld=%b sum=%0d expected all 0", o_busy, o_in_ready, o_out_valid, o_out_sum);
        end
        tick;
        reset_n = 1;
        tick;
        start_job(3);
        send(4'h8, 50);
        send(4'h0, 99);
        send(4'h3, 1);
        exp_q.push_back(exp_acc);
        wait_result("zero_codes");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_back_to_back;
        test_zero_len;
        test_bubbles;
        test_hold_done;
        test_abort;
        test_reset_drain;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
